// File: rtl/ibex_rf_init_ctrl_if.sv
// rtl/ibex_rf_init_ctrl_if.sv - core writeback and register file port bundle for the init controller
interface ibex_rf_init_ctrl_if #(
    parameter int DataWidth = 32
) ();
    logic [4:0]           core_waddr_i;
    logic [DataWidth-1:0] core_wdata_i;
    logic                 core_we_i;
    logic                 core_ready_o;
    logic [4:0]           rf_waddr_o;
    logic [DataWidth-1:0] rf_wdata_o;
    logic                 rf_we_o;
    logic [4:0]           rf_raddr_o;
    logic [DataWidth-1:0] rf_rdata_i;

    // Controller side: takes core writes, drives the register file ports
    modport slave (
        input  core_waddr_i, core_wdata_i, core_we_i, rf_rdata_i,
        output core_ready_o, rf_waddr_o, rf_wdata_o, rf_we_o, rf_raddr_o
    );

    // Environment side: core writeback plus register file
    modport master (
        output core_waddr_i, core_wdata_i, core_we_i, rf_rdata_i,
        input  core_ready_o, rf_waddr_o, rf_wdata_o, rf_we_o, rf_raddr_o
    );
endinterface

// File: rtl/ibex_rf_init_ctrl.sv
// rtl/ibex_rf_init_ctrl.sv - sweeps x1..xLast to InitVal after reset or on request, then forwards core writes
module ibex_rf_init_ctrl #(
    parameter bit                 RV32E      = 1'b0,
    parameter int                 DataWidth  = 32,
    parameter logic [DataWidth-1:0] InitVal  = '0,
    parameter bit                 VerifyInit = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 init_req_i,
    ibex_rf_init_ctrl_if.slave   bus,
    output logic                 init_busy_o,
    output logic                 init_done_o,
    output logic                 init_err_o
);
    typedef enum logic [1:0] {
        StStart,
        StWrite,
        StCheck,
        StDone
    } state_e;

    localparam logic [4:0] LastAddr = RV32E ? 5'd15 : 5'd31;

    state_e     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StStart;
            cnt_q   <= 5'd1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        err_d            = err_q;
        bus.rf_we_o      = 1'b0;
        bus.rf_waddr_o   = 5'd0;
        bus.rf_wdata_o   = '0;
        bus.rf_raddr_o   = 5'd0;
        bus.core_ready_o = 1'b0;
        unique case (state_q)
            StStart: begin
                state_d = StWrite;
            end
            StWrite: begin
                bus.rf_we_o    = 1'b1;
                bus.rf_waddr_o = cnt_q;
                bus.rf_wdata_o = InitVal;
                if (VerifyInit) begin
                    state_d = StCheck;
                end else if (cnt_q == LastAddr) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            StCheck: begin
                // The read port is combinational, so the word written last cycle is visible now
                bus.rf_raddr_o = cnt_q;
                if (bus.rf_rdata_i != InitVal) begin
                    err_d = 1'b1;
                end
                if (cnt_q == LastAddr) begin
                    state_d = StDone;
                end else begin
                    cnt_d   = cnt_q + 5'd1;
                    state_d = StWrite;
                end
            end
            StDone: begin
                bus.core_ready_o = 1'b1;
                bus.rf_we_o      = bus.core_we_i;
                bus.rf_waddr_o   = bus.core_waddr_i;
                bus.rf_wdata_o   = bus.core_wdata_i;
                // A core write in the request cycle still lands; the sweep follows it
                if (init_req_i) begin
                    state_d = StStart;
                    cnt_d   = 5'd1;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = StStart;
            end
        endcase
    end

    assign init_busy_o = (state_q != StDone);
    assign init_done_o = (state_q == StDone);
    assign init_err_o  = err_q;
endmodule
